// File: rtl/data_memory_pkg.sv
// Shared types and elaboration-time checks for the synchronous data memory.
package data_memory_pkg;

    typedef enum logic {
        MS_CLEAR = 1'b0,
        MS_IDLE  = 1'b1
    } mem_state_e;

    // True when the word count fits in the address space and is non-zero.
    function automatic bit depth_ok(input int depth, input int addr_w);
        longint limit;
        limit = longint'(1) << addr_w;
        return (depth >= 1) && (longint'(depth) <= limit);
    endfunction

endpackage

// File: rtl/data_memory_sync_mem_array.sv
// Single-clock storage array: synchronous write, registered read-before-write.
module mem_array #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];

    // Both ports in one block so a same-address read sees the pre-write word.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr[IDX_W-1:0]] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr[IDX_W-1:0]];
        end
    end

endmodule

// File: rtl/data_memory_sync.sv
// Clocked data memory with zero-fill sweep, registered reads and range checking.
module data_memory_sync
    import data_memory_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] r_a,
    input  logic [DATA_W-1:0] r_b,
    input  logic              clear_req,
    output logic              busy,
    output logic              rd_valid,
    output logic [DATA_W-1:0] data_out,
    output logic              addr_err
);

    localparam logic [ADDR_W:0] DEPTH_W  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST_PTR = (ADDR_W+1)'(DEPTH - 1);

    if (!depth_ok(DEPTH, ADDR_W)) begin : g_bad_params
        $error("data_memory_sync: DEPTH must satisfy 1 <= DEPTH <= 2**ADDR_W");
    end

    mem_state_e        state_q, state_d;
    logic [ADDR_W:0]   ptr_q, ptr_d;
    logic              rd_valid_q, rd_valid_d;
    logic              addr_err_q, addr_err_d;
    logic              zero_q, zero_d;
    logic              sweeping, req_ok, in_range, user_we, user_re;
    logic              arr_we;
    logic [ADDR_W-1:0] arr_waddr;
    logic [DATA_W-1:0] arr_wdata, arr_rdata;

    assign sweeping = (state_q == MS_CLEAR);
    assign req_ok   = (state_q == MS_IDLE) && !clear_req;
    assign in_range = ({1'b0, r_a} < DEPTH_W);
    assign user_we  = req_ok && mem_write && in_range;
    assign user_re  = req_ok && mem_read && in_range;

    assign arr_we    = sweeping || user_we;
    assign arr_waddr = sweeping ? ptr_q[ADDR_W-1:0] : r_a;
    assign arr_wdata = sweeping ? '0 : r_b;

    // The array read register is not reset, so a flag forces zero after reset and out-of-range reads.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        rd_valid_d = req_ok && mem_read;
        addr_err_d = req_ok && (mem_read || mem_write) && !in_range;
        zero_d     = (req_ok && mem_read) ? !in_range : zero_q;
        unique case (state_q)
            MS_CLEAR: begin
                ptr_d = ptr_q + (ADDR_W+1)'(1);
                if (ptr_q == LAST_PTR) begin
                    state_d = MS_IDLE;
                    ptr_d   = '0;
                end
            end
            MS_IDLE: begin
                if (clear_req) begin
                    state_d = MS_CLEAR;
                    ptr_d   = '0;
                end
            end
            default: state_d = MS_CLEAR;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= MS_CLEAR;
            ptr_q      <= '0;
            rd_valid_q <= 1'b0;
            addr_err_q <= 1'b0;
            zero_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            rd_valid_q <= rd_valid_d;
            addr_err_q <= addr_err_d;
            zero_q     <= zero_d;
        end
    end

    mem_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .waddr (arr_waddr),
        .wdata (arr_wdata),
        .re    (user_re),
        .raddr (r_a),
        .rdata (arr_rdata)
    );

    assign busy     = sweeping;
    assign rd_valid = rd_valid_q;
    assign addr_err = addr_err_q;
    assign data_out = zero_q ? '0 : arr_rdata;

endmodule
